// File: rtl/sprite_overlay.sv
// Sprite overlay: scan-position hit test, ROM fetch, animation frames and blinking.
// Optional macro SPRITE_OVERLAY_TRANSPARENT_EN: pixels equal to KEY_COLOR are transparent.
module sprite_overlay #(
    parameter int unsigned WIDTH           = 177,
    parameter int unsigned HEIGHT          = 26,
    parameter int unsigned FRAMES          = 1,
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned ROM_LAT         = 0,
    parameter int unsigned TICKS_PER_FRAME = 8,
    parameter int unsigned BLINK_TICKS     = 30,
    parameter logic [15:0] DEFAULT_COLOR   = 16'hffff,
    parameter logic [15:0] KEY_COLOR       = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    input  logic [9:0]        posx,
    input  logic [8:0]        posy,
    input  logic              isplay,
    input  logic              frame_tick,
    input  logic              anim_en,
    input  logic              blink_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [15:0]       color,
    output logic              is_display
);

    localparam int unsigned FRAME_SZ   = WIDTH * HEIGHT;
    localparam logic [15:0] ANIM_LAST  = 16'(TICKS_PER_FRAME - 1);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_TICKS - 1);
    localparam logic [3:0]  FRAME_LAST = 4'(FRAMES - 1);

    logic [15:0] color_d, color_q;
    logic        is_display_d, is_display_q;
    logic [3:0]  frame_idx_d, frame_idx_q;
    logic [15:0] anim_cnt_d, anim_cnt_q;
    logic [15:0] blink_cnt_d, blink_cnt_q;
    logic        visible_d, visible_q;

    logic        hit;
    logic        hit_dly;
    logic        pix_hit;
    logic [10:0] x_end;
    logic [9:0]  y_end;
    logic [9:0]  dx;
    logic [8:0]  dy;
    logic [31:0] addr_full;

    // Widened end coordinates so a sprite near the right/bottom edge clips instead of wrapping.
    always_comb begin
        x_end = {1'b0, posx} + 11'(WIDTH);
        y_end = {1'b0, posy} + 10'(HEIGHT);
        hit   = isplay & visible_q & (x >= posx) & ({1'b0, x} < x_end)
                & (y >= posy) & ({1'b0, y} < y_end);
        dx        = x - posx;
        dy        = y - posy;
        addr_full = 32'(frame_idx_q) * 32'(FRAME_SZ) + 32'(dy) * 32'(WIDTH) + 32'(dx);
        rom_addr  = hit ? addr_full[ADDR_W-1:0] : '0;
    end

    generate
        if (ROM_LAT == 0) begin : g_lat0
            assign hit_dly = hit;
        end else begin : g_latn
            logic [ROM_LAT-1:0] hit_sr_d, hit_sr_q;

            always_comb begin
                hit_sr_d = (hit_sr_q << 1) | ROM_LAT'(hit);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    hit_sr_q <= '0;
                end else begin
                    hit_sr_q <= hit_sr_d;
                end
            end

            assign hit_dly = hit_sr_q[ROM_LAT-1];
        end
    endgenerate

    always_comb begin
        pix_hit = hit_dly;
`ifdef SPRITE_OVERLAY_TRANSPARENT_EN
        if (rom_data == KEY_COLOR) begin
            pix_hit = 1'b0;
        end
`endif
        color_d      = pix_hit ? rom_data : DEFAULT_COLOR;
        is_display_d = pix_hit;
    end

`ifndef SPRITE_OVERLAY_TRANSPARENT_EN
    logic unused_key;
    assign unused_key = ^KEY_COLOR;
`endif

    always_comb begin
        anim_cnt_d  = anim_cnt_q;
        frame_idx_d = frame_idx_q;
        if (frame_tick && anim_en) begin
            if (anim_cnt_q == ANIM_LAST) begin
                anim_cnt_d  = '0;
                frame_idx_d = (frame_idx_q == FRAME_LAST) ? 4'd0 : frame_idx_q + 4'd1;
            end else begin
                anim_cnt_d = anim_cnt_q + 16'd1;
            end
        end
    end

    // Disabling blink forces the sprite visible and restarts the half-period.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        visible_d   = visible_q;
        if (!blink_en) begin
            blink_cnt_d = '0;
            visible_d   = 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                visible_d   = ~visible_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color_q      <= DEFAULT_COLOR;
            is_display_q <= 1'b0;
            frame_idx_q  <= '0;
            anim_cnt_q   <= '0;
            blink_cnt_q  <= '0;
            visible_q    <= 1'b1;
        end else begin
            color_q      <= color_d;
            is_display_q <= is_display_d;
            frame_idx_q  <= frame_idx_d;
            anim_cnt_q   <= anim_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            visible_q    <= visible_d;
        end
    end

    assign color      = color_q;
    assign is_display = is_display_q;

endmodule

// File: tb/tb_sprite_overlay.sv
// Randomised self-checking bench for sprite_overlay: one asynchronous-ROM and one
// registered-ROM instance share stimulus and are compared with a frame/tick-level model.
module tb_sprite_overlay;

    localparam int unsigned W   = 177;
    localparam int unsigned H   = 26;
    localparam int unsigned FR  = 3;
    localparam int unsigned TPF = 2;
    localparam int unsigned BT  = 2;
    localparam logic [15:0] DEF = 16'hffff;
    localparam logic [15:0] KEY = 16'h0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, isplay, frame_tick, anim_en, blink_en;
    logic [9:0]  x, posx;
    logic [8:0]  y, posy;
    logic [15:0] addr_a, addr_b, data_a, data_b, color_a, color_b;
    logic        disp_a, disp_b;

    int total = 0;
    int bad = 0;

    // Model state: enabled animation ticks and blink ticks since blink was last disabled.
    int anim_ticks = 0;
    int blink_ticks = 0;
    logic [15:0] exp_addr, act_addr_a, act_addr_b;
    logic [15:0] exp_color_a, exp_color_b, pend_color;
    logic        exp_disp_a, exp_disp_b, pend_disp;

    function automatic logic [15:0] rom_fn(input logic [15:0] a);
        logic [31:0] v;
        if ((a % 16'd7) == 16'd3) return KEY;
        v = (32'(a) * 32'd40503) ^ 32'h5a5a;
        if (v[15:0] == 16'hffff || v[15:0] == 16'h0000) return 16'h1357;
        return v[15:0];
    endfunction

    assign data_a = rom_fn(addr_a);
    always @(posedge clk) data_b <= rom_fn(addr_b);

    sprite_overlay #(
        .WIDTH(W), .HEIGHT(H), .FRAMES(FR), .ADDR_W(16), .ROM_LAT(0),
        .TICKS_PER_FRAME(TPF), .BLINK_TICKS(BT), .DEFAULT_COLOR(DEF), .KEY_COLOR(KEY)
    ) dut_a (
        .clk(clk), .rst(rst), .x(x), .y(y), .posx(posx), .posy(posy), .isplay(isplay),
        .frame_tick(frame_tick), .anim_en(anim_en), .blink_en(blink_en),
        .rom_addr(addr_a), .rom_data(data_a), .color(color_a), .is_display(disp_a)
    );

    sprite_overlay #(
        .WIDTH(W), .HEIGHT(H), .FRAMES(FR), .ADDR_W(16), .ROM_LAT(1),
        .TICKS_PER_FRAME(TPF), .BLINK_TICKS(BT), .DEFAULT_COLOR(DEF), .KEY_COLOR(KEY)
    ) dut_b (
        .clk(clk), .rst(rst), .x(x), .y(y), .posx(posx), .posy(posy), .isplay(isplay),
        .frame_tick(frame_tick), .anim_en(anim_en), .blink_en(blink_en),
        .rom_addr(addr_b), .rom_data(data_b), .color(color_b), .is_display(disp_b)
    );

    function automatic bit model_hit();
        bit vis;
        vis = ((blink_ticks / BT) % 2) == 0;
        return isplay && vis && int'(x) >= int'(posx) && int'(x) < int'(posx) + W
            && int'(y) >= int'(posy) && int'(y) < int'(posy) + H;
    endfunction

    function automatic logic [15:0] model_addr();
        int frame;
        frame = (anim_ticks / TPF) % FR;
        return 16'(frame * W * H + (int'(y) - int'(posy)) * W + (int'(x) - int'(posx)));
    endfunction

    // One clock: sample rom_addr before the edge, advance the model, leave at negedge.
    task automatic step();
        bit h, pd;
        logic [15:0] a, pc;
        #1;
        h = model_hit();
        a = h ? model_addr() : 16'h0;
        exp_addr   = a;
        act_addr_a = addr_a;
        act_addr_b = addr_b;
        pd = h;
        pc = h ? rom_fn(a) : DEF;
`ifdef SPRITE_OVERLAY_TRANSPARENT_EN
        if (h && rom_fn(a) == KEY) begin
            pd = 1'b0;
            pc = DEF;
        end
`endif
        @(posedge clk);
        if (rst) begin
            exp_disp_a = 1'b0; exp_color_a = DEF;
            exp_disp_b = 1'b0; exp_color_b = DEF;
            pend_disp  = 1'b0; pend_color  = DEF;
            anim_ticks  = 0;
            blink_ticks = 0;
        end else begin
            exp_disp_a = pd;        exp_color_a = pc;
            exp_disp_b = pend_disp; exp_color_b = pend_color;
            pend_disp  = pd;        pend_color  = pc;
            if (frame_tick && anim_en) anim_ticks++;
            if (!blink_en) blink_ticks = 0;
            else if (frame_tick) blink_ticks++;
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input int px, input int py, input int sx, input int sy);
        rst = r; posx = 10'(px); posy = 9'(py); x = 10'(sx); y = 9'(sy);
        isplay = 1'b1; frame_tick = 1'b0; anim_en = 1'b0; blink_en = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 100, 50, 105, 52);
        step();
        total++;
        if (disp_a !== 1'b0 || color_a !== DEF || disp_b !== 1'b0 || color_b !== DEF) begin
            bad++;
            $display("FAIL reset_out: got a=%b/%h b=%b/%h want 0/%h", disp_a, color_a,
                     disp_b, color_b, DEF);
        end
        rst = 1'b0;
        step();
        total++;
        if (disp_b !== 1'b0 || color_b !== DEF || disp_a !== exp_disp_a
            || color_a !== exp_color_a) begin
            bad++;
            $display("FAIL reset_release: got a=%b/%h b=%b/%h want a=%b/%h b=0/%h", disp_a,
                     color_a, disp_b, color_b, exp_disp_a, exp_color_a, DEF);
        end
    endtask

    task automatic test_scan();
        int xs[7] = '{99, 100, 101, 276, 277, 100, 100};
        int ys[7] = '{50, 50, 50, 50, 50, 75, 76};
        bit ds[7] = '{0, 1, 1, 1, 0, 1, 0};
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 100, 50, xs[i], ys[i]);
            step();
            total++;
            if (disp_a !== ds[i] || color_a !== exp_color_a || disp_a !== exp_disp_a) begin
                bad++;
                $display("FAIL scan_a x=%0d y=%0d: got %b/%h want %b/%h", xs[i], ys[i],
                         disp_a, color_a, ds[i], exp_color_a);
            end
            total++;
            if (act_addr_a !== exp_addr || act_addr_b !== exp_addr) begin
                bad++;
                $display("FAIL scan_addr x=%0d: got a=%0d b=%0d want %0d", xs[i],
                         act_addr_a, act_addr_b, exp_addr);
            end
            total++;
            if (disp_b !== exp_disp_b || color_b !== exp_color_b) begin
                bad++;
                $display("FAIL scan_b x=%0d: got %b/%h want %b/%h", xs[i], disp_b, color_b,
                         exp_disp_b, exp_color_b);
            end
        end
    endtask

    task automatic test_anim();
        int tbl[7] = '{0, 0, 4602, 4602, 9204, 9204, 0};
        drive(1'b1, 100, 50, 100, 50);
        step();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 100, 50, 100, 50);
            anim_en = 1'b1;
            frame_tick = 1'b1;
            step();
            total++;
            if (act_addr_a !== 16'(tbl[k]) || act_addr_b !== 16'(tbl[k])) begin
                bad++;
                $display("FAIL anim_tick k=%0d: got a=%0d b=%0d want %0d", k, act_addr_a,
                         act_addr_b, tbl[k]);
            end
            frame_tick = 1'b0;
            step();
            total++;
            if (act_addr_a !== 16'(tbl[k+1]) || color_a !== exp_color_a
                || disp_a !== exp_disp_a) begin
                bad++;
                $display("FAIL anim_after k=%0d: got %0d %b/%h want %0d %b/%h", k,
                         act_addr_a, disp_a, color_a, tbl[k+1], exp_disp_a, exp_color_a);
            end
        end
    endtask

    task automatic test_blink();
        bit vis_after[6] = '{1, 0, 0, 1, 1, 0};
        drive(1'b1, 100, 50, 105, 50);
        step();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 100, 50, 105, 50);
            blink_en = 1'b1;
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
            total++;
            if (disp_a !== vis_after[k] || disp_b !== exp_disp_b) begin
                bad++;
                $display("FAIL blink tick=%0d: got a=%b b=%b want a=%b b=%b", k + 1, disp_a,
                         disp_b, vis_after[k], exp_disp_b);
            end
        end
        blink_en = 1'b0;
        step();
        total++;
        if (disp_a !== 1'b0) begin
            bad++;
            $display("FAIL blink_drop_same: got %b want 0", disp_a);
        end
        step();
        total++;
        if (disp_a !== 1'b1 || color_a !== exp_color_a) begin
            bad++;
            $display("FAIL blink_drop_next: got %b/%h want 1/%h", disp_a, color_a, exp_color_a);
        end
    endtask

    task automatic test_clip();
        drive(1'b1, 600, 100, 600, 100);
        step();
        for (int sx = 598; sx < 640; sx++) begin
            drive(1'b0, 600, 100, sx, 100);
            step();
            total++;
            if (disp_a !== exp_disp_a || color_a !== exp_color_a || act_addr_a !== exp_addr
                || disp_b !== exp_disp_b || color_b !== exp_color_b) begin
                bad++;
                $display("FAIL clip x=%0d: got a=%b/%h @%0d b=%b/%h want a=%b/%h @%0d b=%b/%h",
                         sx, disp_a, color_a, act_addr_a, disp_b, color_b, exp_disp_a,
                         exp_color_a, exp_addr, exp_disp_b, exp_color_b);
            end
            if (sx == 603) begin
                total++;
`ifdef SPRITE_OVERLAY_TRANSPARENT_EN
                if (disp_a !== 1'b0 || color_a !== DEF) begin
                    bad++;
                    $display("FAIL clip_key: got %b/%h want 0/%h", disp_a, color_a, DEF);
                end
`else
                if (disp_a !== 1'b1 || color_a !== 16'h0000) begin
                    bad++;
                    $display("FAIL clip_key: got %b/%h want 1/0000", disp_a, color_a);
                end
`endif
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 100, 50, 100, 50);
        step();
        drive(1'b0, 100, 50, 100, 50);
        anim_en = 1'b1;
        frame_tick = 1'b1;
        step();
        step();
        frame_tick = 1'b0;
        rst = 1'b1;
        step();
        total++;
        if (act_addr_a !== 16'd4602 || disp_a !== 1'b0 || color_a !== DEF
            || disp_b !== 1'b0 || color_b !== DEF) begin
            bad++;
            $display("FAIL reset_mid: got addr=%0d a=%b/%h b=%b/%h want 4602 0/%h 0/%h",
                     act_addr_a, disp_a, color_a, disp_b, color_b, DEF, DEF);
        end
        rst = 1'b0;
        step();
        total++;
        if (act_addr_a !== 16'd0 || disp_b !== 1'b0 || color_b !== DEF
            || color_a !== rom_fn(16'd0)) begin
            bad++;
            $display("FAIL reset_mid_after: got addr=%0d a=%h b=%b/%h want 0 %h 0/%h",
                     act_addr_a, color_a, disp_b, color_b, rom_fn(16'd0), DEF);
        end
    endtask

    task automatic test_random();
        int px, py;
        px = 100;
        py = 50;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                px = int'($urandom_range(0, 639));
                py = int'($urandom_range(0, 479));
            end
            drive($urandom_range(0, 59) == 0, px, py,
                  px + int'($urandom_range(0, 200)) - 10, py + int'($urandom_range(0, 32)) - 3);
            isplay     = $urandom_range(0, 9) != 0;
            frame_tick = $urandom_range(0, 4) == 0;
            anim_en    = $urandom_range(0, 5) != 0;
            blink_en   = $urandom_range(0, 7) != 0;
            step();
            total++;
            if (act_addr_a !== exp_addr || act_addr_b !== exp_addr || disp_a !== exp_disp_a
                || color_a !== exp_color_a || disp_b !== exp_disp_b
                || color_b !== exp_color_b) begin
                bad++;
                $display("FAIL random n=%0d: got @%0d/%0d a=%b/%h b=%b/%h want @%0d a=%b/%h b=%b/%h",
                         n, act_addr_a, act_addr_b, disp_a, color_a, disp_b, color_b, exp_addr,
                         exp_disp_a, exp_color_a, exp_disp_b, exp_color_b);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drive(1'b1, 100, 50, 0, 0);
        exp_disp_a = 1'b0; exp_color_a = DEF;
        exp_disp_b = 1'b0; exp_color_b = DEF;
        pend_disp  = 1'b0; pend_color  = DEF;
        @(negedge clk);
        test_reset();
        test_scan();
        test_anim();
        test_blink();
        test_clip();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
